// File: rtl/axi4mm_pkg.sv
// Shared AXI4 memory-mapped encodings and arbiter state type, reused by the
// read-side and write-side arbiters.
package axi4mm_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10
   } axi_burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      RESP
   } arb_state_e;

endpackage

// File: rtl/axi4mm_wr_arbiter_rr_priority_pick.sv
// Round-robin pick: first set request at or above ptr_i, wrapping, as a
// one-hot vector plus its index. Pure combinational.
module rr_priority_pick
   import axi4mm_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [IDX_W-1:0] k;
   logic             found;

   always_comb begin
      pick_o = '0;
      idx_o  = '0;
      found  = 1'b0;
      k      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = IDX_W'((32'(ptr_i) + i) % NUM_REQ);
         if (!found && req_i[k]) begin
            pick_o[k] = 1'b1;
            idx_o     = k;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4mm_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write port (AW/W/B) between NUM_REQ
// requesters, one transaction at a time, with beat-count and B-ID checking.
module axi4mm_wr_arbiter
   import axi4mm_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 8,
   parameter int ID_W    = 3
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [NUM_REQ-1:0]           s_awvalid,
   output logic [NUM_REQ-1:0]           s_awready,
   input  logic [NUM_REQ*ADDR_W-1:0]    s_awaddr,
   input  logic [NUM_REQ*LEN_W-1:0]     s_awlen,
   input  logic [NUM_REQ*3-1:0]         s_awsize,
   input  logic [NUM_REQ*2-1:0]         s_awburst,
   input  logic [NUM_REQ*DATA_W-1:0]    s_wdata,
   input  logic [NUM_REQ*DATA_W/8-1:0]  s_wstrb,
   input  logic [NUM_REQ-1:0]           s_wlast,
   input  logic [NUM_REQ-1:0]           s_wvalid,
   output logic [NUM_REQ-1:0]           s_wready,
   output logic [1:0]                   s_bresp,
   output logic [NUM_REQ-1:0]           s_bvalid,
   input  logic [NUM_REQ-1:0]           s_bready,
   output logic                         m_awvalid,
   input  logic                         m_awready,
   output logic [ID_W-1:0]              m_awid,
   output logic [ADDR_W-1:0]            m_awaddr,
   output logic [LEN_W-1:0]             m_awlen,
   output logic [2:0]                   m_awsize,
   output logic [1:0]                   m_awburst,
   output logic [DATA_W-1:0]            m_wdata,
   output logic [DATA_W/8-1:0]          m_wstrb,
   output logic                         m_wlast,
   output logic                         m_wvalid,
   input  logic                         m_wready,
   input  logic [ID_W-1:0]              m_bid,
   input  logic [1:0]                   m_bresp,
   input  logic                         m_bvalid,
   output logic                         m_bready,
   output logic [NUM_REQ-1:0]           grant,
   output logic                         busy,
   output logic                         prot_err
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int STRB_W = DATA_W / 8;

   arb_state_e         state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDX_W-1:0]   g_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [LEN_W-1:0]   beat_cnt_q;
   logic [LEN_W-1:0]   len_q;
   logic               prot_err_q;

   logic [NUM_REQ-1:0] pick;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   next_ptr;
   logic               aw_hs;
   logic               w_hs;
   logic               b_hs;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i  (s_awvalid),
      .ptr_i  (rr_ptr_q),
      .pick_o (pick),
      .idx_o  (pick_idx)
   );

   // Channels are only routed in their own phase; everything else reads as 0.
   always_comb begin
      s_awready = '0;
      s_wready  = '0;
      s_bvalid  = '0;
      s_bresp   = '0;
      m_awvalid = 1'b0;
      m_awid    = '0;
      m_awaddr  = '0;
      m_awlen   = '0;
      m_awsize  = '0;
      m_awburst = '0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wlast   = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      case (state_q)
         ADDR: begin
            m_awvalid      = s_awvalid[g_q];
            s_awready[g_q] = m_awready;
            m_awid         = ID_W'(g_q);
            m_awaddr       = s_awaddr[g_q*ADDR_W +: ADDR_W];
            m_awlen        = s_awlen[g_q*LEN_W +: LEN_W];
            m_awsize       = s_awsize[g_q*3 +: 3];
            m_awburst      = s_awburst[g_q*2 +: 2];
         end
         DATA: begin
            m_wvalid      = s_wvalid[g_q];
            s_wready[g_q] = m_wready;
            m_wdata       = s_wdata[g_q*DATA_W +: DATA_W];
            m_wstrb       = s_wstrb[g_q*STRB_W +: STRB_W];
            m_wlast       = s_wlast[g_q];
         end
         RESP: begin
            s_bvalid[g_q] = m_bvalid;
            m_bready      = s_bready[g_q];
            s_bresp       = m_bresp;
         end
         default: ;
      endcase
   end

   assign aw_hs    = m_awvalid & m_awready;
   assign w_hs     = m_wvalid & m_wready;
   assign b_hs     = m_bvalid & m_bready;
   assign next_ptr = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         g_q        <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         len_q      <= '0;
         prot_err_q <= 1'b0;
      end else begin
         prot_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|s_awvalid) begin
                  grant_q <= pick;
                  g_q     <= pick_idx;
                  state_q <= ADDR;
               end
            end
            ADDR: begin
               if (aw_hs) begin
                  len_q      <= m_awlen;
                  beat_cnt_q <= '0;
                  state_q    <= DATA;
               end
            end
            DATA: begin
               if (w_hs) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  // Flags both early wlast and a missing wlast on the final beat.
                  if (m_wlast != (beat_cnt_q == len_q)) prot_err_q <= 1'b1;
                  if (m_wlast) state_q <= RESP;
               end
            end
            RESP: begin
               if (b_hs) begin
                  if (m_bid != ID_W'(g_q)) prot_err_q <= 1'b1;
                  rr_ptr_q <= next_ptr;
                  grant_q  <= '0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant    = grant_q;
   assign busy     = (state_q != IDLE);
   assign prot_err = prot_err_q;

endmodule

// File: tb/tb_axi4mm_wr_arbiter.sv
// Directed bench for axi4mm_wr_arbiter: a table of whole write transactions
// plus hand-written reset sequences.
module tb_axi4mm_wr_arbiter;

   localparam int N  = 2;
   localparam int AW = 20;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int IW = 3;
   localparam int SW = DW / 8;

   logic              aclk    = 1'b0;
   logic              aresetn = 1'b1;
   logic [N-1:0]      s_awvalid = '0;
   logic [N-1:0]      s_awready;
   logic [N*AW-1:0]   s_awaddr  = '0;
   logic [N*LW-1:0]   s_awlen   = '0;
   logic [N*3-1:0]    s_awsize  = '0;
   logic [N*2-1:0]    s_awburst = '0;
   logic [N*DW-1:0]   s_wdata   = '0;
   logic [N*SW-1:0]   s_wstrb   = '0;
   logic [N-1:0]      s_wlast   = '0;
   logic [N-1:0]      s_wvalid  = '0;
   logic [N-1:0]      s_wready;
   logic [1:0]        s_bresp;
   logic [N-1:0]      s_bvalid;
   logic [N-1:0]      s_bready  = '0;
   logic              m_awvalid;
   logic              m_awready = 1'b0;
   logic [IW-1:0]     m_awid;
   logic [AW-1:0]     m_awaddr;
   logic [LW-1:0]     m_awlen;
   logic [2:0]        m_awsize;
   logic [1:0]        m_awburst;
   logic [DW-1:0]     m_wdata;
   logic [SW-1:0]     m_wstrb;
   logic              m_wlast;
   logic              m_wvalid;
   logic              m_wready  = 1'b0;
   logic [IW-1:0]     m_bid     = '0;
   logic [1:0]        m_bresp   = '0;
   logic              m_bvalid  = 1'b0;
   logic              m_bready;
   logic [N-1:0]      grant;
   logic              busy;
   logic              prot_err;

   axi4mm_wr_arbiter #(
      .NUM_REQ (N),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .LEN_W   (LW),
      .ID_W    (IW)
   ) dut (
      .aclk      (aclk),      .aresetn   (aresetn),
      .s_awvalid (s_awvalid), .s_awready (s_awready),
      .s_awaddr  (s_awaddr),  .s_awlen   (s_awlen),
      .s_awsize  (s_awsize),  .s_awburst (s_awburst),
      .s_wdata   (s_wdata),   .s_wstrb   (s_wstrb),
      .s_wlast   (s_wlast),   .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),  .s_bresp   (s_bresp),
      .s_bvalid  (s_bvalid),  .s_bready  (s_bready),
      .m_awvalid (m_awvalid), .m_awready (m_awready),
      .m_awid    (m_awid),    .m_awaddr  (m_awaddr),
      .m_awlen   (m_awlen),   .m_awsize  (m_awsize),
      .m_awburst (m_awburst), .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),   .m_wlast   (m_wlast),
      .m_wvalid  (m_wvalid),  .m_wready  (m_wready),
      .m_bid     (m_bid),     .m_bresp   (m_bresp),
      .m_bvalid  (m_bvalid),  .m_bready  (m_bready),
      .grant     (grant),     .busy      (busy),
      .prot_err  (prot_err)
   );

   always #5 aclk = ~aclk;

   int tests_run    = 0;
   int tests_failed = 0;
   int perr_cnt     = 0;
   int wbeat_cnt    = 0;
   int leak_cnt     = 0;

   // Passive monitors sampled mid-cycle.
   always @(negedge aclk) begin
      if (prot_err) perr_cnt++;
      if (m_wvalid && m_wready) wbeat_cnt++;
      if (((s_awready | s_wready | s_bvalid) & ~grant) != '0) leak_cnt++;
   end

   typedef struct {
      logic [N-1:0]  mask;      // s_awvalid at row start
      int            win;       // expected winner
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      int            last_idx;  // beat index carrying wlast
      logic [IW-1:0] bid;
      logic [1:0]    bresp;
      int            stall;     // cycles from row start before m_awready rises
      bit            wtog;      // toggle m_wready every cycle
      bit            drop;      // winner drops awvalid after AW handshake
      int            exp_wait;  // cycles from row start to AW handshake
      int            exp_perr;  // prot_err pulses expected
   } row_t;

   row_t rows [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"},     grant,     0);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_prot_err"},  prot_err,  0);
      check({tag, "_m_awvalid"}, m_awvalid, 0);
      check({tag, "_m_wvalid"},  m_wvalid,  0);
      check({tag, "_m_bready"},  m_bready,  0);
      check({tag, "_s_awready"}, s_awready, 0);
      check({tag, "_s_wready"},  s_wready,  0);
      check({tag, "_s_bvalid"},  s_bvalid,  0);
      check({tag, "_m_awaddr"},  m_awaddr,  0);
      check({tag, "_m_wdata"},   m_wdata,   0);
   endtask

   task automatic do_txn(input row_t t, input int tag);
      int  cyc;
      int  beats;
      int  other;
      int  perr_base;
      int  wbeat_base;
      bit  hs;
      logic [DW-1:0] d;
      logic [SW-1:0] st;
      other      = (t.win == 0) ? 1 : 0;
      perr_base  = perr_cnt;
      wbeat_base = wbeat_cnt;
      s_awvalid  = t.mask;
      s_awaddr[t.win*AW +: AW] = t.addr;
      s_awlen[t.win*LW +: LW]  = t.len;
      s_awsize[t.win*3 +: 3]   = 3'b010;
      s_awburst[t.win*2 +: 2]  = 2'b01;
      check($sformatf("r%0d_idle_at_start", tag), busy, 0);
      // AW phase
      hs = 1'b0;
      cyc = 0;
      while (!hs && cyc < 40) begin
         m_awready = (cyc >= t.stall);
         #1;
         if (m_awvalid && m_awready) begin
            hs = 1'b1;
            check($sformatf("r%0d_aw_wait", tag), cyc, t.exp_wait);
            check($sformatf("r%0d_awid", tag), m_awid, t.win);
            check($sformatf("r%0d_grant", tag), grant, 1 << t.win);
            check($sformatf("r%0d_awaddr", tag), m_awaddr, t.addr);
            check($sformatf("r%0d_awlen", tag), m_awlen, t.len);
            check($sformatf("r%0d_awsize_burst", tag), {m_awsize, m_awburst}, 5'b010_01);
         end
         @(posedge aclk); #1;
         if (!hs) cyc++;
      end
      if (!hs) check($sformatf("r%0d_aw_timeout", tag), 0, 1);
      m_awready = 1'b0;
      if (t.drop) s_awvalid[t.win] = 1'b0;
      // W phase
      beats = 0;
      cyc = 0;
      while (beats <= t.last_idx && cyc < 100) begin
         d  = {8'hD0 + 8'(t.win), 8'(tag), 16'(beats)};
         st = SW'(beats + 1);
         s_wvalid[t.win] = 1'b1;
         s_wdata[t.win*DW +: DW] = d;
         s_wstrb[t.win*SW +: SW] = st;
         s_wlast[t.win] = (beats == t.last_idx);
         m_wready = t.wtog ? ((cyc % 2) == 1) : 1'b1;
         #1;
         hs = m_wvalid && m_wready;
         if (hs) begin
            check($sformatf("r%0d_wdata_b%0d", tag, beats), m_wdata, d);
            check($sformatf("r%0d_wstrb_b%0d", tag, beats), m_wstrb, st);
            check($sformatf("r%0d_wlast_b%0d", tag, beats), m_wlast, beats == t.last_idx);
         end
         @(posedge aclk); #1;
         if (hs) beats++;
         cyc++;
      end
      if (beats <= t.last_idx) check($sformatf("r%0d_w_timeout", tag), 0, 1);
      s_wvalid = '0;
      s_wlast  = '0;
      m_wready = 1'b0;
      // B phase
      m_bvalid = 1'b1;
      m_bid    = t.bid;
      m_bresp  = t.bresp;
      s_bready[t.win] = 1'b1;
      hs = 1'b0;
      cyc = 0;
      while (!hs && cyc < 10) begin
         #1;
         if (s_bvalid[t.win] && m_bready) begin
            hs = 1'b1;
            check($sformatf("r%0d_bresp", tag), s_bresp, t.bresp);
            check($sformatf("r%0d_bvalid_other", tag), s_bvalid[other], 0);
         end
         @(posedge aclk); #1;
         cyc++;
      end
      if (!hs) check($sformatf("r%0d_b_timeout", tag), 0, 1);
      m_bvalid = 1'b0;
      m_bid    = '0;
      s_bready = '0;
      @(negedge aclk); #1;
      check($sformatf("r%0d_grant_cleared", tag), grant, 0);
      check($sformatf("r%0d_beats_fwd", tag), wbeat_cnt - wbeat_base, t.last_idx + 1);
      check($sformatf("r%0d_prot_err_pulses", tag), perr_cnt - perr_base, t.exp_perr);
   endtask

   initial begin
      int perr_base;
      //           mask   win addr       len  last bid   bresp  stall tog drop wait perr
      rows[0]  = '{2'b11, 0, 20'h00100, 8'd1, 1, 3'd0, 2'b00, 0, 1'b0, 1'b0, 1, 0};
      rows[1]  = '{2'b11, 1, 20'h00200, 8'd1, 1, 3'd1, 2'b00, 0, 1'b0, 1'b0, 1, 0};
      rows[2]  = '{2'b11, 0, 20'h00300, 8'd1, 1, 3'd0, 2'b00, 0, 1'b0, 1'b0, 1, 0};
      rows[3]  = '{2'b11, 1, 20'h00400, 8'd1, 1, 3'd1, 2'b00, 0, 1'b0, 1'b1, 1, 0};
      rows[4]  = '{2'b11, 0, 20'h00500, 8'd7, 7, 3'd0, 2'b00, 5, 1'b1, 1'b1, 5, 0};
      rows[5]  = '{2'b10, 1, 20'h00600, 8'd0, 0, 3'd1, 2'b01, 0, 1'b0, 1'b1, 1, 0};
      rows[6]  = '{2'b01, 0, 20'h00100, 8'd3, 3, 3'd0, 2'b00, 0, 1'b0, 1'b0, 1, 0};
      rows[7]  = '{2'b11, 1, 20'h00700, 8'd1, 1, 3'd1, 2'b00, 0, 1'b0, 1'b1, 1, 0};
      rows[8]  = '{2'b01, 0, 20'h00800, 8'd3, 2, 3'd0, 2'b10, 0, 1'b0, 1'b0, 1, 1};
      rows[9]  = '{2'b01, 0, 20'h00900, 8'd0, 0, 3'd1, 2'b00, 0, 1'b0, 1'b0, 1, 1};
      rows[10] = '{2'b01, 0, 20'h00A00, 8'd1, 2, 3'd0, 2'b11, 0, 1'b0, 1'b1, 1, 2};

      // Asynchronous reset before any clock edge.
      #1 aresetn = 1'b0;
      #1 check_reset_outputs("por");
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;

      for (int i = 0; i < 11; i++) do_txn(rows[i], i);

      // Reset in the middle of a 4-beat burst, after two beats; rr_ptr is 1 here.
      perr_base = perr_cnt;
      s_awvalid = 2'b01;
      s_awaddr[0 +: AW] = 20'h00B00;
      s_awlen[0 +: LW]  = 8'd3;
      m_awready = 1'b1;
      @(posedge aclk); #1;
      check("rst_seq_awvalid", m_awvalid, 1);
      @(posedge aclk); #1;
      s_awvalid = '0;
      m_awready = 1'b0;
      s_wvalid[0] = 1'b1;
      s_wdata[0 +: DW] = 32'hCAFE_0000;
      s_wstrb[0 +: SW] = 4'hF;
      m_wready = 1'b1;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      check("rst_seq_busy_mid_data", busy, 1);
      check("rst_seq_wvalid_mid_data", m_wvalid, 1);
      aresetn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      s_wvalid = '0;
      m_wready = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      check("rst_seq_no_prot_err", perr_cnt - perr_base, 0);
      // Both request: pointer is back at 0, so requester 0 must win.
      do_txn('{2'b11, 0, 20'h00C00, 8'd1, 1, 3'd0, 2'b00, 0, 1'b0, 1'b1, 1, 0}, 11);
      s_awvalid = '0;

      check("no_ready_or_bvalid_to_ungranted", leak_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axi4mm_wr_arbiter.md
Name: axi4mm_wr_arbiter

Overview:
Shares one AXI4 memory-mapped write port (AW/W/B) between NUM_REQ DMA write requesters using rotating (round-robin) priority. It allows one transaction at a time. A grant is held from AW acceptance through the final B handshake, and the W and B channels are routed to the granted requester. The block sits between the DMA write engines and the memory-side AXI4 write slave, and also checks beat count and response ID.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 20, address width (1 MB space)
DATA_W, 32, write data width
LEN_W, 8, awlen width
ID_W, 3, m_awid/m_bid width; must be >= clog2(NUM_REQ)

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
s_awvalid  in  NUM_REQ  per-requester AW valid
s_awready  out  NUM_REQ  per-requester AW ready
s_awaddr  in  NUM_REQ*ADDR_W  packed; requester i at [i*ADDR_W +: ADDR_W]
s_awlen  in  NUM_REQ*LEN_W  packed burst lengths (beats-1)
s_awsize  in  NUM_REQ*3  packed burst sizes
s_awburst  in  NUM_REQ*2  packed burst types
s_wdata  in  NUM_REQ*DATA_W  packed write data
s_wstrb  in  NUM_REQ*DATA_W/8  packed byte strobes
s_wlast, s_wvalid  in  NUM_REQ  per-requester W last/valid
s_wready  out  NUM_REQ  per-requester W ready
s_bresp  out  2  response code, valid only at the granted index
s_bvalid  out  NUM_REQ  per-requester B valid
s_bready  in  NUM_REQ  per-requester B ready
m_awvalid/m_awready  out/in  1  master AW handshake
m_awid  out  ID_W  equals grant index
m_awaddr, m_awlen, m_awsize, m_awburst  out  ADDR_W, LEN_W, 3, 2  muxed AW payload
m_wdata, m_wstrb, m_wlast, m_wvalid  out  DATA_W, DATA_W/8, 1, 1  muxed W channel
m_wready  in  1  master W ready
m_bid, m_bresp, m_bvalid  in  ID_W, 2, 1  B channel
m_bready  out  1  master B ready
grant  out  NUM_REQ  one-hot current grant, 0 when IDLE
busy  out  1  1 in any state other than IDLE
prot_err  out  1  one-cycle pulse on a protocol check failure

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, len_q=0, busy=0, prot_err=0. All m_*valid, m_bready, s_*ready and s_bvalid are 0. The AW/W payload outputs are 0.
- Reset asserted mid-transaction drops everything to reset values immediately. No partial completion is signalled. The slave shares aresetn.
- IDLE: if any s_awvalid is set, pick the first set bit scanning from rr_ptr upward with wrap. Register grant and g, then go to ADDR. m_awvalid rises in the cycle after the request is seen in IDLE (1-cycle arbitration latency).
- ADDR: m_aw* is combinationally muxed from requester g, with m_awvalid = s_awvalid[g] and s_awready[g] = m_awready. On the m_awvalid && m_awready handshake, latch len_q = awlen, clear beat_cnt, and go to DATA.
- DATA: m_w* is muxed from g, with s_wready[g] = m_wready. Each accepted beat increments beat_cnt.
  - On an accepted beat with wlast=1, go to RESP.
  - If wlast arrives with beat_cnt != len_q, or beat_cnt reaches len_q without wlast, pulse prot_err. Transition still follows wlast only.
- RESP: s_bvalid[g] = m_bvalid, m_bready = s_bready[g], and s_bresp = m_bresp.
  - If m_bid != g during m_bvalid, pulse prot_err; the response is still delivered.
  - On the B handshake, set rr_ptr = (g+1) mod NUM_REQ, clear grant, and go to IDLE.
- Non-granted requesters always see s_awready=0, s_wready=0, s_bvalid=0. Their requests stay pending.
- Fairness: a continuously requesting requester is granted within NUM_REQ-1 completed transactions.
- Same-cycle B completion and new request: the new request is arbitrated in the following IDLE cycle. Minimum turnaround is one IDLE cycle between transactions.
- Requester deasserting awvalid in ADDR is illegal AXI; the arbiter holds in ADDR (no timeout).
- awlen=0 (single beat): wlast on the first beat is legal and gives no error.

Decomposition:
- Shared package axi4mm_pkg holds:
  - burst encodings FIXED=2'b00, INCR=2'b01, WRAP=2'b10
  - response codes OKAY/EXOKAY/SLVERR/DECERR
  - arbiter state enum IDLE/ADDR/DATA/RESP
- One sub-module, rr_priority_pick: combinational; inputs are the request vector and rr_ptr; outputs are the one-hot pick and its index. It is reusable by the read-side arbiter.

Test Plan:
- Single request: req0 awaddr=0x00100, awlen=3, m_awready tied 1, 4 beats, bresp=OKAY → m_awid=0, 4 beats passed through, s_bvalid[0]=1, prot_err never pulses, rr_ptr=1.
- Contention: req0 and req1 assert in the same cycle, rr_ptr=0, back-to-back bursts → grants alternate 0,1,0,1 over 4 transactions, with exactly one IDLE cycle between each.
- Backpressure: m_awready low 5 cycles, m_wready toggling each cycle, awlen=7 → exactly 8 beats forwarded in order, req1 sees no ready throughout, and data matches a scoreboard.
- Length error: awlen=3 with wlast on beat 2 → prot_err pulses once, state goes to RESP, and the B response is still delivered to req0.
- ID error: slave returns m_bid=1 for the req0 grant → prot_err pulses once and s_bvalid[0] (not [1]) asserts.
- Reset mid-DATA: aresetn low after beat 2 of 4 → all valid/ready outputs go to 0 immediately, grant=0, busy=0. After release, the first request wins from rr_ptr=0.
